serial_add_ctrl: RTL and testbench
==================================

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 SHALL have parameter: WIDTH, 16, operand width in bits; a legal value is a multiple of 4 and at least 8.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: clr  input  1  synchronous abort; discards the operation in flight.
REQ-005 SHALL have port: in_valid  input  1  request valid.
REQ-006 SHALL have port: in_ready  output  1  request accepted when in_valid & in_ready at a rising edge.
REQ-007 SHALL have port: a  input  WIDTH  operand A.
REQ-008 SHALL have port: b  input  WIDTH  operand B.
REQ-009 SHALL have port: sub  input  1  0 = A+B, 1 = A-B.
REQ-010 SHALL have port: out_valid  output  1  result valid.
REQ-011 SHALL have port: out_ready  input  1  consumer accepts the result when out_valid & out_ready at a rising edge.
REQ-012 SHALL have port: result  output  WIDTH  sum or difference, modulo 2^WIDTH.
REQ-013 SHALL have port: cout  output  1  carry out of the MSB; for subtraction 1 = no borrow.
REQ-014 SHALL have port: ovf  output  1  two's-complement signed overflow.
REQ-015 SHALL have port: busy  output  1  high in RUN or DONE.

Function
REQ-016 SHALL compute the result with exactly one 4-bit carry-lookahead adder slice, used once per cycle, least-significant nibble first; NIBBLES = WIDTH/4.
REQ-017 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-018 SHALL drive in_ready = 1 only in IDLE; in_ready SHALL be registered-state-derived and SHALL NOT depend combinationally on in_valid.
REQ-019 On accept, SHALL capture a, b XOR {WIDTH{sub}}, and sub into registers, set the carry register to sub, clear the nibble counter, and go IDLE->RUN.
REQ-020 In RUN, each cycle SHALL add captured-A nibble i, captured-B' nibble i and the carry register; it SHALL write sum nibble i into the result register, store the slice carry-out, and increment i.
REQ-021 On the edge that writes nibble NIBBLES-1, SHALL go RUN->DONE, store the final carry as cout, and store ovf = (A[MSB] == B'[MSB]) & (result[MSB] != A[MSB]).
REQ-022 Latency: if accept occurs at rising edge T, out_valid SHALL be 1 after edge T+NIBBLES; no earlier and no later.
REQ-023 In DONE, SHALL hold out_valid = 1 with result, cout and ovf stable until out_valid & out_ready; on that edge it SHALL go DONE->IDLE.
REQ-024 out_valid SHALL be 0 in IDLE and RUN; result, cout and ovf SHALL be treated as undefined-but-stable outside DONE and are not checked.
REQ-025 Input changes on a, b or sub after accept SHALL NOT affect the operation in flight.
REQ-026 in_valid in RUN or DONE SHALL be ignored; a request held through DONE SHALL be accepted at the first IDLE edge, giving a minimum spacing of NIBBLES+2 cycles between accepts.
REQ-027 clr = 1 at an edge SHALL force IDLE, out_valid = 0 and counter = 0; clr SHALL take priority over accept and over the out handshake on the same edge.
REQ-028 Wrap-around: the result SHALL be modulo 2^WIDTH, with the carry reported only via cout.

Reset
REQ-029 While rst_n = 0, SHALL immediately force: state IDLE, in_ready 1, out_valid 0, busy 0, result 0, cout 0, ovf 0, counter 0, carry 0.
REQ-030 Reset asserted during RUN or DONE SHALL discard the operation, with no out_valid after release.
REQ-031 The first accept SHALL be possible at the first rising edge after rst_n deasserts.

Verification (WIDTH=16)
REQ-032 Add 0xFFFF + 0x0001 accepted at edge T -> out_valid after edge T+4; result 0x0000, cout 1, ovf 0.
REQ-033 Add 0x7FFF + 0x0001 -> result 0x8000, cout 0, ovf 1; sub 0x8000 - 0x0001 -> 0x7FFF, cout 1, ovf 1; sub 0x0000 - 0x0001 -> 0xFFFF, cout 0, ovf 0.
REQ-034 Backpressure: out_ready low 3 cycles after out_valid -> result, cout and ovf stable; in_ready 0 with in_valid held high; next request accepted at the first edge after the out handshake.
REQ-035 Operands changed every cycle during RUN -> result equals the operation on the captured values (0x1234 + 0x4321 = 0x5555).
REQ-036 rst_n pulsed low during RUN (after 2 nibbles) -> outputs reset immediately; no out_valid afterward; a new add 0x0001 + 0x0001 -> 0x0002.
REQ-037 clr during RUN and clr coincident with in_valid in IDLE -> state IDLE, out_valid 0, no accept on that edge.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// Nibble-serial adder/subtractor: one 4-bit carry-lookahead slice reused for
// WIDTH/4 cycles, with a valid/ready request side and a valid/ready result side.
module serial_add_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic [3:0] a_nib, b_nib, g, p, sum;
  logic [4:0] c;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  assign a_nib = a_reg[{cnt, 2'b00} +: 4];
  assign b_nib = b_reg[{cnt, 2'b00} +: 4];

  // Single 4-bit carry-lookahead slice; carry into nibble 0 is the captured sub.
  always_comb begin
    g    = a_nib & b_nib;
    p    = a_nib ^ b_nib;
    c[0] = carry;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c[0]);
    sum  = p ^ c[3:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_reg  <= '0;
      b_reg  <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      result <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else if (clr) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg <= a;
            b_reg <= b ^ {WIDTH{sub}};
            carry <= sub;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          result[{cnt, 2'b00} +: 4] <= sum;
          carry <= c[4];
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            cout  <= c[4];
            ovf   <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) & (sum[3] != a_reg[WIDTH-1]);
            cnt   <= '0;
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl at WIDTH=16 with hand-computed results.
module tb_serial_add_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, clr, in_valid, in_ready, sub, out_valid, out_ready;
  logic        cout, ovf, busy;
  logic [15:0] a, b, result;
  int          total = 0;
  int          bad = 0;

  serial_add_ctrl #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .cout(cout), .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a request and lets it be accepted on the next edge.
  task automatic start_op(input string tag, input logic [15:0] aa, input logic [15:0] bb, input logic s);
    a = aa; b = bb; sub = s; in_valid = 1'b1;
    check({tag, ".in_ready"}, in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    check({tag, ".busy"}, busy, 1'b1);
  endtask

  task automatic wait_done(input string tag);
    for (int i = 1; i < 4; i++) begin
      tick();
      check({tag, ".early_valid"}, out_valid, 1'b0);
    end
    tick();
    check({tag, ".out_valid"}, out_valid, 1'b1);
  endtask

  task automatic check_result(input string tag, input logic [15:0] r, input logic co, input logic ov);
    check({tag, ".result"}, result, r);
    check({tag, ".cout"}, cout, co);
    check({tag, ".ovf"}, ovf, ov);
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, ".post_valid"}, out_valid, 1'b0);
    check({tag, ".post_ready"}, in_ready, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; sub = 1'b0;
    #12;
    check("rst.in_ready", in_ready, 1'b1);
    check("rst.out_valid", out_valid, 1'b0);
    check("rst.busy", busy, 1'b0);
    check_result("rst", 16'h0000, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Arithmetic corner cases
    start_op("add_wrap", 16'hFFFF, 16'h0001, 1'b0);
    wait_done("add_wrap");
    check_result("add_wrap", 16'h0000, 1'b1, 1'b0);
    handshake("add_wrap");

    start_op("add_ovf", 16'h7FFF, 16'h0001, 1'b0);
    wait_done("add_ovf");
    check_result("add_ovf", 16'h8000, 1'b0, 1'b1);
    handshake("add_ovf");

    start_op("sub_ovf", 16'h8000, 16'h0001, 1'b1);
    wait_done("sub_ovf");
    check_result("sub_ovf", 16'h7FFF, 1'b1, 1'b1);
    handshake("sub_ovf");

    start_op("sub_borrow", 16'h0000, 16'h0001, 1'b1);
    wait_done("sub_borrow");
    check_result("sub_borrow", 16'hFFFF, 1'b0, 1'b0);
    handshake("sub_borrow");

    // Backpressure with a new request held through DONE
    start_op("bp", 16'h00FF, 16'h0F01, 1'b0);
    wait_done("bp");
    a = 16'h0002; b = 16'h0003; sub = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp.hold_valid", out_valid, 1'b1);
      check("bp.hold_ready", in_ready, 1'b0);
      check_result("bp.hold", 16'h1000, 1'b0, 1'b0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp.idle_ready", in_ready, 1'b1);
    check("bp.idle_valid", out_valid, 1'b0);
    tick();
    in_valid = 1'b0;
    check("bp.next_accept", busy, 1'b1);
    wait_done("bp_next");
    check_result("bp_next", 16'h0005, 1'b0, 1'b0);
    handshake("bp_next");

    // Operands scrambled while the operation is in flight
    start_op("scramble", 16'h1234, 16'h4321, 1'b0);
    for (int i = 0; i < 4; i++) begin
      a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom);
      tick();
    end
    check("scramble.out_valid", out_valid, 1'b1);
    check_result("scramble", 16'h5555, 1'b0, 1'b0);
    handshake("scramble");

    // Asynchronous reset after two nibbles
    start_op("rst_run", 16'hABCD, 16'h1111, 1'b0);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("rst_run.in_ready", in_ready, 1'b1);
    check("rst_run.out_valid", out_valid, 1'b0);
    check("rst_run.busy", busy, 1'b0);
    check_result("rst_run", 16'h0000, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check("rst_run.no_valid", out_valid, 1'b0);
      tick();
    end
    start_op("after_rst", 16'h0001, 16'h0001, 1'b0);
    wait_done("after_rst");
    check_result("after_rst", 16'h0002, 1'b0, 1'b0);
    handshake("after_rst");

    // clr while running
    start_op("clr_run", 16'h1111, 16'h2222, 1'b0);
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_run.in_ready", in_ready, 1'b1);
    check("clr_run.busy", busy, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check("clr_run.no_valid", out_valid, 1'b0);
      tick();
    end

    // clr coincident with a request in IDLE
    a = 16'h0F0F; b = 16'h0101; sub = 1'b0; in_valid = 1'b1; clr = 1'b1;
    tick();
    clr = 1'b0; in_valid = 1'b0;
    check("clr_idle.busy", busy, 1'b0);
    check("clr_idle.in_ready", in_ready, 1'b1);
    check("clr_idle.out_valid", out_valid, 1'b0);

    start_op("after_clr", 16'h0010, 16'h0020, 1'b0);
    wait_done("after_clr");
    check_result("after_clr", 16'h0030, 1'b0, 1'b0);
    handshake("after_clr");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
